// File: rtl/instruction_fetch_unit.sv
// Fetch stage of the RV32I core: holds the program counter, requests words from
// instruction memory over a ready/valid handshake and presents each fetched word
// with its PC to decode. The next PC follows the sequential path or a redirect
// (PC-relative branch/JAL, or JALR from rs1), and a misaligned target parks the
// unit in a sticky FAULT state until reset.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic        RedirectSel,
    input  logic [31:0] Immediate,
    input  logic [31:0] JalrBase,
    output logic        MemReq,
    output logic [31:0] MemAddr,
    input  logic        MemReady,
    input  logic [31:0] MemRdata,
    output logic [31:0] Instruction,
    output logic        InstrValid,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        MisalignedFault
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        VALID = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_pc;
    logic [31:0] w_next_pc;
    logic [31:0] r_instr;
    logic [31:0] w_next_instr;
    logic        r_fault;
    logic        w_next_fault;
    logic [31:0] w_target;

    // Next-PC selection; sums wrap modulo 2^32 and JALR clears bit 0 of its target.
    function automatic logic [31:0] f_target(
        input logic [31:0] pc,
        input logic        redirect,
        input logic        sel,
        input logic [31:0] imm,
        input logic [31:0] base
    );
        logic [31:0] sum;
        if (!redirect) begin
            sum = pc + 32'd4;
        end else if (!sel) begin
            sum = pc + imm;
        end else begin
            sum = (base + imm) & ~32'd1;
        end
        return sum;
    endfunction

    assign w_target = f_target(r_pc, Redirect, RedirectSel, Immediate, JalrBase);

    // Outputs are decoded from state or taken straight from registers, so no
    // input reaches them combinationally; only PCPlus4 is arithmetic on PC.
    assign MemReq          = (r_state == REQ);
    assign MemAddr         = r_pc;
    assign InstrValid      = (r_state == VALID);
    assign Instruction     = r_instr;
    assign PC              = r_pc;
    assign PCPlus4         = r_pc + 32'd4;
    assign MisalignedFault = r_fault;

    // Next-state and next-register values; Stall matters only while VALID.
    always_comb begin
        w_next_state = r_state;
        w_next_pc    = r_pc;
        w_next_instr = r_instr;
        w_next_fault = r_fault;
        case (r_state)
            IDLE: begin
                w_next_state = REQ;
            end
            REQ: begin
                if (MemReady) begin
                    w_next_instr = MemRdata;
                    w_next_state = VALID;
                end
            end
            VALID: begin
                if (!Stall) begin
                    w_next_pc    = w_target;
                    w_next_instr = NOP_INSTR;
                    if (w_target[1:0] == 2'b00) begin
                        w_next_state = REQ;
                    end else begin
                        w_next_fault = 1'b1;
                        w_next_state = FAULT;
                    end
                end
            end
            FAULT: begin
                w_next_state = FAULT;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight response.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= IDLE;
            r_pc    <= RESET_VECTOR;
            r_instr <= NOP_INSTR;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_next_pc;
            r_instr <= w_next_instr;
            r_fault <= w_next_fault;
        end
    end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch stage of the RV32I core, directly upstream of ImmediateGenerator and the decoder. Holds the program counter and requests instructions from instruction memory over a ready/valid handshake. Presents each fetched word, with its PC, to decode, and computes the next PC from the redirect inputs (branch/JAL via the decoded immediate, JALR via rs1). It stalls for variable-latency memory and flags misaligned fetch targets.

## Interface
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
- NOP_INSTR, 32'h0000_0013, value driven on Instruction when no valid instruction is held (addi x0,x0,0)

- Clock  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-high reset
- Stall  input  1  downstream cannot accept the held instruction this cycle
- Redirect  input  1  held instruction changes control flow; qualifies RedirectSel
- RedirectSel  input  1  0: target = PC + Immediate (branch/JAL); 1: target = (JalrBase + Immediate) & ~1
- Immediate  input  32  sign-extended immediate from ImmediateGenerator
- JalrBase  input  32  rs1 value for JALR
- MemReq  output  1  fetch request valid
- MemAddr  output  32  fetch address
- MemReady  input  1  memory returns MemRdata for the current request this cycle
- MemRdata  input  32  fetched instruction word
- Instruction  output  32  held instruction to decode
- InstrValid  output  1  Instruction is valid
- PC  output  32  address of held/requested instruction
- PCPlus4  output  32  PC + 4, combinational, for JAL/JALR link
- MisalignedFault  output  1  sticky: a next-PC target had bits [1:0] != 0

## Operation
- States: IDLE, REQ, VALID, FAULT.
- Reset (async, any state): state=IDLE, PC=RESET_VECTOR, Instruction=NOP_INSTR, InstrValid=0, MemReq=0, MisalignedFault=0. PCPlus4 = RESET_VECTOR+4.
- IDLE: MemReq=0; goes to REQ unconditionally on the next edge.
- REQ: MemReq=1, MemAddr=PC, held stable until accepted. If MemReady=1 at an edge, Instruction<=MemRdata and the state goes to VALID. Stall is ignored in REQ.
- VALID: InstrValid=1, MemReq=0, Instruction held.
  - Edge with Stall=1: hold everything; Redirect/RedirectSel/Immediate/JalrBase are ignored.
  - Edge with Stall=0 (consume): compute next PC.
    - Redirect=0: PC+4.
    - Redirect=1, RedirectSel=0: PC+Immediate.
    - Redirect=1, RedirectSel=1: (JalrBase+Immediate) with bit 0 cleared.
  - If next PC[1:0]==0: PC<=next, Instruction<=NOP_INSTR, state goes to REQ.
  - Otherwise: PC<=next (faulting address visible on PC), MisalignedFault<=1, Instruction<=NOP_INSTR, state goes to FAULT.
- FAULT: terminal until Reset. MemReq=0, InstrValid=0, Instruction=NOP_INSTR, MisalignedFault=1.
- Arithmetic: all sums are 32-bit modulo 2^32; carry is discarded (0xFFFF_FFFC+4 = 0x0000_0000).
- Instruction equals NOP_INSTR whenever InstrValid=0.

## Timing
- MemAddr, MemReq, InstrValid, Instruction, PC and MisalignedFault are registered or decoded from state; no combinational path from any input to them.
- PCPlus4 is combinational from PC only.
- Reset release: IDLE for 1 cycle, then MemReq=1 in the 2nd cycle after release.
- Fetch latency: MemReady in the same cycle as MemReq gives InstrValid=1 on the next cycle. Each extra cycle without MemReady adds 1 cycle.
- Throughput with zero-wait memory and Stall=0: one instruction every 2 cycles (REQ, VALID).
- Reset asserted in the same cycle as MemReady=1: the response is discarded and the state is IDLE.
- Redirect arriving while state is REQ or IDLE has no effect.

## Test plan
- Reset release, MemReady tied 1, memory returns 0x00500093 at 0x0 -> MemReq=1 at 0x0 in cycle 2; InstrValid=1, Instruction=0x00500093, PC=0, PCPlus4=4 in cycle 3; next MemAddr=0x4.
- MemReady low 3 cycles in REQ -> MemAddr stays at the PC value and MemReq stays 1 for 4 cycles; InstrValid rises the cycle after MemReady=1.
- VALID at PC=0x100, Stall=1 for 2 cycles with Redirect=1, Immediate=0x40, then Stall=0, Redirect=0 -> stalled cycles leave PC=0x100; next MemAddr=0x104.
- PC=0x100, consume with Redirect=1, RedirectSel=0, Immediate=0xFFFF_FFF0 -> next MemAddr=0xF0. With RedirectSel=1, JalrBase=0x2001, Immediate=0x3 -> 0x2004.
- Consume with PC=0x10, Redirect=1, RedirectSel=0, Immediate=0x6 -> PC=0x16, MisalignedFault=1, MemReq=0 thereafter; Reset clears it.
- PC=0xFFFF_FFFC, consume with Redirect=0 -> next MemAddr=0x0. Reset asserted mid-REQ with MemReady=1 -> InstrValid=0, Instruction=0x00000013, PC=RESET_VECTOR.
